spi_aes_master: RTL and testbench
=================================

# spi_aes_master

Serial front end that drives the AES SPI slave. A 128-bit plaintext block and an Nk-word key are latched from the host side. The block serializes them LSB-first onto `SIMO` while `mode` is held low, then raises `mode` and shifts the 128-bit decrypted result back in from `SOMI`. It sits directly upstream of the slave and makes one full encrypt/decrypt round trip per `start`.

## Interface
- `Nk`, default 4: key length in 32-bit words (4/6/8); key field is Nk*32 bits.
- `clk`  in  1  single system clock, shared with the slave; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request a transaction; accepted only in IDLE.
- `msg_in`  in  128  plaintext block, sampled on the accepted `start` edge.
- `key_in`  in  Nk*32  key, sampled on the accepted `start` edge.
- `SIMO`  out  1  serial data to slave.
- `mode`  out  1  0 = load/encrypt phase, 1 = readback phase.
- `SOMI`  in  1  serial data from slave.
- `busy`  out  1  high from the cycle after accept until DONE is left.
- `done`  out  1  one-cycle pulse when `result` is valid.
- `result`  out  128  received block, bit k = k-th received bit; holds until next DONE.

## Operation
- States: IDLE, SEND_MSG, SEND_KEY, GAP, RX_LAT, RECV, DONE.
- Counter `cnt` is 9 bits, sized for max(128, Nk*32) = 256, and is cleared on every state entry.
- IDLE: `SIMO`=0, `mode`=0, `busy`=0. On `start`=1, load shift regs `msg_sr`←`msg_in` and `key_sr`←`key_in`, then go to SEND_MSG. `start` in any other state is ignored.
- SEND_MSG: `SIMO`=`msg_sr[0]`; right-shift `msg_sr` each cycle. After 128 cycles (`cnt`=127), go to SEND_KEY.
- SEND_KEY: `SIMO`=`key_sr[0]`; right-shift each cycle. After Nk*32 cycles, go to GAP.
- GAP: 1 cycle, `SIMO`=0, `mode`=0. This gives the slave's combinational cipher path its settle cycle.
- RX_LAT: 1 cycle with `mode`=1 and no capture. This absorbs the slave's registered `SOMI` latency.
- RECV: `mode`=1. Each cycle, `rx_sr` ← {`SOMI`, `rx_sr[127:1]`}. After 128 cycles, copy `rx_sr` to `result` and go to DONE.
- DONE: `done`=1 and `mode`=0 for one cycle, then go to IDLE.
- `mode` stays 0 in every state except RX_LAT and RECV.
- Async reset mid-transaction: all state is cleared immediately and no `done` is issued. The slave's counters are not reset by this block. Recovery of the slave is a system-level reset concern.

## Timing
- Reset values: `SIMO`=0, `mode`=0, `busy`=0, `done`=0, `result`=0, state=IDLE, all shift regs and `cnt` = 0.
- `SIMO`, `mode`, `busy` and `done` are all registered outputs.
- Edge 0 is the `start` accept edge. `SIMO` carries `msg_in[k]` in the cycle after edge 1+k, for k = 0..127.
- `key_in[k]` is driven in the cycle after edge 129+k.
- GAP occupies the cycle after edge 129+Nk*32, and RX_LAT the cycle after it.
- RECV capture edges are 132+Nk*32 through 259+Nk*32.
- `done` is high in the cycle after edge 259+Nk*32. That is cycle 387 for Nk=4, 451 for Nk=6, 515 for Nk=8.
- `result` is updated on the same edge that asserts `done`.
- `start` held high through DONE does not retrigger until IDLE is re-entered. A new accept is possible on the edge after `done`.

## Test plan
- Reset then idle: hold `rst_n`=0 for 3 cycles, release, hold `start`=0 for 20 cycles -> all outputs 0; `mode` never toggles.
- Serialization, Nk=4: `msg_in`=128'h00112233445566778899aabbccddeeff, `key_in`=128'h000102030405060708090a0b0c0d0e0f -> the `SIMO` bit stream equals `msg_in` LSB-first for 128 cycles, then `key_in` LSB-first for 128 cycles. `busy`=1 throughout.
- Loopback readback: tie `SOMI` to a model that emits 128'hdeadbeef_01234567_89abcdef_cafef00d LSB-first, starting on the first RECV capture edge -> `result`=128'hdeadbeef_01234567_89abcdef_cafef00d. `done` pulses exactly once, at cycle 387.
- End-to-end with the slave, FIPS-197 C.1 vector (key 000102..0f, plaintext 00112233..eeff) -> `result` = plaintext, `done` pulses once, `mode` is high for exactly 129 cycles.
- Nk=8 build -> key phase lasts 256 cycles and `done` arrives at cycle 515.
- Abuse: pulse `start` during SEND_KEY (ignored, latched data unchanged). Assert `rst_n`=0 for 1 cycle inside RECV -> outputs return to reset values asynchronously and no `done` is issued. A fresh `start` afterwards completes normally.

Source files
------------

// File: rtl/spi_aes_master.sv
// Serial front end for the AES SPI slave: shifts plaintext then key out LSB-first on SIMO,
// then raises mode and collects the 128-bit result from SOMI.
module spi_aes_master #(
    parameter int unsigned Nk = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [127:0]      msg_in,
    input  logic [Nk*32-1:0]  key_in,
    output logic              SIMO,
    output logic              mode,
    input  logic              SOMI,
    output logic              busy,
    output logic              done,
    output logic [127:0]      result
);
    localparam int unsigned KW       = Nk * 32;
    localparam logic [8:0]  MSG_LAST = 9'd127;
    localparam logic [8:0]  KEY_LAST = 9'(KW - 1);

    typedef enum logic [2:0] {
        IDLE, SEND_MSG, SEND_KEY, GAP, RX_LAT, RECV, DONE
    } state_t;

    state_t          state, state_nx;
    logic [8:0]      cnt;
    logic [127:0]    msg_sr;
    logic [KW-1:0]   key_sr;
    logic [127:0]    rx_sr;
    logic [127:0]    rx_nx;
    logic            rx_en;
    logic            simo_nx, mode_nx, busy_nx, done_nx;

    assign rx_nx = {SOMI, rx_sr[127:1]};

    always_comb begin
        state_nx = state;
        simo_nx  = 1'b0;
        mode_nx  = 1'b0;
        busy_nx  = 1'b1;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                busy_nx = start;
                if (start) state_nx = SEND_MSG;
            end
            SEND_MSG: begin
                simo_nx = msg_sr[0];
                if (cnt == MSG_LAST) state_nx = SEND_KEY;
            end
            SEND_KEY: begin
                simo_nx = key_sr[0];
                if (cnt == KEY_LAST) state_nx = GAP;
            end
            GAP:    state_nx = RX_LAT;
            RX_LAT: begin
                mode_nx  = 1'b1;
                state_nx = RECV;
            end
            RECV: begin
                mode_nx = 1'b1;
                if (cnt == MSG_LAST) state_nx = DONE;
            end
            DONE: begin
                done_nx  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered, so they trail the internal state by one cycle; rx_en
    // delays capture by the same cycle so sampling lines up with the visible mode phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            msg_sr <= '0;
            key_sr <= '0;
            rx_sr  <= '0;
            rx_en  <= 1'b0;
            SIMO   <= 1'b0;
            mode   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            state <= state_nx;
            SIMO  <= simo_nx;
            mode  <= mode_nx;
            busy  <= busy_nx;
            done  <= done_nx;
            rx_en <= (state == RECV);

            if (state_nx != state || state == IDLE) cnt <= '0;
            else                                    cnt <= cnt + 9'd1;

            if (state == IDLE && start) begin
                msg_sr <= msg_in;
                key_sr <= key_in;
            end else begin
                if (state == SEND_MSG) msg_sr <= msg_sr >> 1;
                if (state == SEND_KEY) key_sr <= key_sr >> 1;
            end

            if (rx_en)         rx_sr  <= rx_nx;
            if (state == DONE) result <= rx_nx;
        end
    end
endmodule

// File: tb/tb_spi_aes_master.sv
// Directed bench for spi_aes_master: Nk=4 instance for most scenarios plus an Nk=8 instance.
module tb_spi_aes_master;
    localparam logic [127:0] MSG_A = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PAT_B = 128'hdeadbeef0123456789abcdefcafef00d;
    localparam logic [127:0] PAT_C = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [255:0] KEY_8 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, start, somi, simo, mode, busy, done;
    logic [127:0] msg_in, key_in, result;
    logic         start8, somi8, simo8, mode8, busy8, done8;
    logic [127:0] msg8, result8;
    logic [255:0] key8;

    int errors = 0;
    int checks = 0;

    spi_aes_master #(.Nk(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .msg_in(msg_in), .key_in(key_in),
        .SIMO(simo), .mode(mode), .SOMI(somi), .busy(busy), .done(done), .result(result)
    );

    spi_aes_master #(.Nk(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .msg_in(msg8), .key_in(key8),
        .SIMO(simo8), .mode(mode8), .SOMI(somi8), .busy(busy8), .done(done8), .result(result8)
    );

    // Observations from the most recent Nk=4 transaction
    logic [255:0] tx_bits;
    int mode_hi, done_cnt, done_cyc, busy_lo;

    // Runs one Nk=4 transaction; n is the edge index relative to the accept edge,
    // sampling happens on the negedge of the cycle after edge n.
    task automatic run4(input logic [127:0] m, input logic [127:0] k,
                        input logic [127:0] p, input int glitch_at);
        @(negedge clk);
        msg_in = m; key_in = k; start = 1'b1;
        tx_bits = '0; mode_hi = 0; done_cnt = 0; done_cyc = -1; busy_lo = 0;
        for (int n = 0; n <= 400; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 0) begin
                start = 1'b0; msg_in = '0; key_in = '0;
            end
            if (n == glitch_at) begin
                start = 1'b1; msg_in = '1; key_in = '1;
            end else if (n == glitch_at + 1) begin
                start = 1'b0; msg_in = '0; key_in = '0;
            end
            if (n >= 1 && n <= 256) tx_bits[n-1] = simo;
            if (mode) mode_hi++;
            if (done) begin done_cnt++; done_cyc = n; end
            if (n <= 387 && !busy) busy_lo++;
            somi = (n >= 259 && n <= 386) ? p[n-259] : 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; somi = 1'b0; msg_in = '0; key_in = '0;
        start8 = 1'b0; somi8 = 1'b0; msg8 = '0; key8 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({simo, mode, busy, done, result} !== 132'd0) begin
            errors++;
            $display("FAIL reset_in: outs=%h required 0", {simo, mode, busy, done, result});
        end
        rst_n = 1'b1;
        begin
            int bad = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if ({simo, mode, busy, done, result} !== 132'd0) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL reset_idle: nonzero cycles=%0d required 0", bad);
            end
        end
    endtask

    task automatic test_serialize();
        run4(MSG_A, KEY_A, 128'd0, -1);
        checks++;
        if (tx_bits !== {KEY_A, MSG_A}) begin
            errors++;
            $display("FAIL serialize_stream: got %h required %h", tx_bits, {KEY_A, MSG_A});
        end
        checks++;
        if (busy_lo != 0) begin
            errors++;
            $display("FAIL serialize_busy: busy-low cycles=%0d required 0", busy_lo);
        end
        checks++;
        if (result !== 128'd0) begin
            errors++;
            $display("FAIL serialize_result: got %h required 0", result);
        end
    endtask

    task automatic test_loopback();
        run4(MSG_A, KEY_A, PAT_B, -1);
        checks++;
        if (result !== PAT_B) begin
            errors++;
            $display("FAIL loopback_result: got %h required %h", result, PAT_B);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 387) begin
            errors++;
            $display("FAIL loopback_done: count=%0d cycle=%0d required 1 at 387", done_cnt, done_cyc);
        end
        checks++;
        if (busy || mode || done) begin
            errors++;
            $display("FAIL loopback_idle: busy=%b mode=%b done=%b required 0", busy, mode, done);
        end
    endtask

    // Slave stand-in: an encrypt/decrypt round trip returns the FIPS-197 C.1 plaintext
    task automatic test_fips_e2e();
        run4(MSG_A, KEY_A, MSG_A, -1);
        checks++;
        if (result !== MSG_A) begin
            errors++;
            $display("FAIL e2e_result: got %h required %h", result, MSG_A);
        end
        checks++;
        if (mode_hi != 129 || done_cnt != 1) begin
            errors++;
            $display("FAIL e2e_mode: mode-high=%0d done=%0d required 129 and 1", mode_hi, done_cnt);
        end
    endtask

    task automatic test_start_abuse();
        run4(MSG_A, KEY_A, PAT_C, 200);
        checks++;
        if (tx_bits !== {KEY_A, MSG_A}) begin
            errors++;
            $display("FAIL abuse_stream: got %h required %h", tx_bits, {KEY_A, MSG_A});
        end
        checks++;
        if (result !== PAT_C || done_cnt != 1 || done_cyc != 387) begin
            errors++;
            $display("FAIL abuse_result: got %h done=%0d@%0d required %h 1@387",
                     result, done_cnt, done_cyc, PAT_C);
        end
    endtask

    task automatic test_reset_in_recv();
        int dn = 0;
        @(negedge clk);
        msg_in = MSG_A; key_in = KEY_A; start = 1'b1;
        for (int n = 0; n <= 300; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 0) start = 1'b0;
            somi = (n >= 259 && n <= 386) ? PAT_B[n-259] : 1'b0;
        end
        checks++;
        if (!mode) begin
            errors++;
            $display("FAIL recv_precondition: mode=%b required 1", mode);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({simo, mode, busy, done, result} !== 132'd0) begin
            errors++;
            $display("FAIL recv_async_reset: outs=%h required 0", {simo, mode, busy, done, result});
        end
        @(negedge clk);
        rst_n = 1'b1;
        somi = 1'b0;
        for (int i = 0; i < 450; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        checks++;
        if (dn != 0 || busy) begin
            errors++;
            $display("FAIL recv_no_done: done pulses=%0d busy=%b required 0 0", dn, busy);
        end
        run4(MSG_A, KEY_A, PAT_C, -1);
        checks++;
        if (result !== PAT_C || done_cyc != 387) begin
            errors++;
            $display("FAIL recv_recover: got %h at %0d required %h at 387", result, done_cyc, PAT_C);
        end
    endtask

    task automatic test_back_to_back();
        int d0 = -1;
        int d1 = -1;
        int dn = 0;
        @(negedge clk);
        msg_in = MSG_A; key_in = KEY_A; start = 1'b1; somi = 1'b0;
        for (int n = 0; n <= 790; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 388) start = 1'b0;
            if (done) begin
                dn++;
                if (d0 < 0) d0 = n; else d1 = n;
            end
        end
        checks++;
        if (dn != 2 || d0 != 387 || d1 != 775) begin
            errors++;
            $display("FAIL back_to_back: pulses=%0d at %0d,%0d required 2 at 387,775", dn, d0, d1);
        end
    endtask

    task automatic test_nk8();
        logic [383:0] bits8 = '0;
        int d8 = -1;
        int dn = 0;
        logic gap_simo = 1'b1;
        @(negedge clk);
        msg8 = MSG_A; key8 = KEY_8; start8 = 1'b1;
        for (int n = 0; n <= 530; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 0) begin start8 = 1'b0; msg8 = '0; key8 = '0; end
            if (n >= 1 && n <= 384) bits8[n-1] = simo8;
            if (n == 385) gap_simo = simo8;
            if (done8) begin dn++; d8 = n; end
            somi8 = (n >= 387 && n <= 514) ? PAT_B[n-387] : 1'b0;
        end
        checks++;
        if (bits8 !== {KEY_8, MSG_A} || gap_simo !== 1'b0) begin
            errors++;
            $display("FAIL nk8_stream: got %h gap=%b required %h gap=0", bits8, gap_simo, {KEY_8, MSG_A});
        end
        checks++;
        if (dn != 1 || d8 != 515 || result8 !== PAT_B) begin
            errors++;
            $display("FAIL nk8_done: pulses=%0d at %0d result=%h required 1 at 515 %h",
                     dn, d8, result8, PAT_B);
        end
    endtask

    initial begin
        test_reset();
        test_serialize();
        test_loopback();
        test_fips_e2e();
        test_start_abuse();
        test_reset_in_recv();
        test_back_to_back();
        test_nk8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
